tqvp_prism_infilt: RTL and testbench

//  Input-conditioning stage directly upstream of the PRISM controller's in_data bus.

---
 rtl/prism_pkg.sv | 8 +
 rtl/prism_glitch_filt.sv | 43 ++++
 rtl/tqvp_prism_infilt.sv | 72 +++++++
 tb/tb_tqvp_prism_infilt.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prism_pkg.sv
// Shared constants for the PRISM input-conditioning stage: default widths and the
// in_data bit span that the filtered bus drives.
package prism_pkg;
   localparam int IN_DATA_LSB      = 0;
   localparam int IN_DATA_MSB      = 7;
   localparam int INFILT_WIDTH     = IN_DATA_MSB - IN_DATA_LSB + 1;
   localparam int INFILT_FILT_BITS = 4;
endpackage

// File: rtl/prism_glitch_filt.sv
// One bit of glitch filtering: stability counter, filtered level, and registered
// rise/fall pulses derived from the filtered level and its delayed copy.
module prism_glitch_filt #(
   parameter int FILT_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 src,
   input  logic                 bypass,
   input  logic [FILT_BITS-1:0] filt_len,
   output logic                 filt,
   output logic                 rise,
   output logic                 fall
);
   logic [FILT_BITS-1:0] cnt;
   logic                 filt_d;

   // cnt never exceeds filt_len, so the increment cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         filt_d <= filt;
         rise   <= filt & ~filt_d;
         fall   <= ~filt & filt_d;
         if (bypass) begin
            filt <= src;
            cnt  <= '0;
         end else if (src == filt) begin
            cnt <= '0;
         end else if (cnt >= filt_len) begin
            filt <= src;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/tqvp_prism_infilt.sv
// Input conditioning ahead of PRISM in_data: per-bit glitch filters, sticky edge flags
// and masked irq. Define PRISM_INFILT_SYNC_EN to add a 2-flop synchronizer on in_raw.
module tqvp_prism_infilt
   import prism_pkg::*;
#(
   parameter int WIDTH     = INFILT_WIDTH,
   parameter int FILT_BITS = INFILT_FILT_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_raw,
   input  logic [FILT_BITS-1:0] filt_len,
   input  logic [WIDTH-1:0]     bypass,
   input  logic [WIDTH-1:0]     rise_en,
   input  logic [WIDTH-1:0]     fall_en,
   input  logic [WIDTH-1:0]     irq_mask,
   input  logic [WIDTH-1:0]     flag_clr,
   output logic [WIDTH-1:0]     in_filt,
   output logic [WIDTH-1:0]     rise,
   output logic [WIDTH-1:0]     fall,
   output logic [WIDTH-1:0]     flags,
   output logic                 irq
);
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] flags_next;

`ifdef PRISM_INFILT_SYNC_EN
   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= in_raw;
         sync_q2 <= sync_q1;
      end
   end
   assign src = sync_q2;
`else
   assign src = in_raw;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      prism_glitch_filt #(.FILT_BITS(FILT_BITS)) u_filt (
         .clk      (clk),
         .rst      (rst),
         .src      (src[i]),
         .bypass   (bypass[i]),
         .filt_len (filt_len),
         .filt     (in_filt[i]),
         .rise     (rise[i]),
         .fall     (fall[i])
      );
   end

   // A new edge in the same cycle as a clear keeps the flag set so no edge is lost.
   always_comb begin
      flags_next = (flags & ~flag_clr) | (rise & rise_en) | (fall & fall_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
         irq   <= 1'b0;
      end else begin
         flags <= flags_next;
         irq   <= |(flags_next & irq_mask);
      end
   end
endmodule

// File: tb/tb_tqvp_prism_infilt.sv
// Directed self-checking bench for tqvp_prism_infilt; honours PRISM_INFILT_SYNC_EN
// by shifting every expected latency by the synchronizer depth.
module tb_tqvp_prism_infilt;
`ifdef PRISM_INFILT_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_raw, bypass, rise_en, fall_en, irq_mask, flag_clr;
   logic [3:0] filt_len;
   logic [7:0] in_filt, rise, fall, flags;
   logic       irq;

   int n_tests = 0;
   int n_fail  = 0;

   tqvp_prism_infilt dut (
      .clk(clk), .rst(rst), .in_raw(in_raw), .filt_len(filt_len), .bypass(bypass),
      .rise_en(rise_en), .fall_en(fall_en), .irq_mask(irq_mask), .flag_clr(flag_clr),
      .in_filt(in_filt), .rise(rise), .fall(fall), .flags(flags), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_raw = '0; bypass = '0; rise_en = '0; fall_en = '0;
      irq_mask = '0; flag_clr = '0; filt_len = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      bypass = 8'hFF; in_raw = 8'hA5; rise_en = 8'hFF; irq_mask = 8'hFF;
      repeat (SL + 4) tick();
      n_tests++;
      if (in_filt !== 8'hA5) begin
         n_fail++; $display("FAIL reset_pre in_filt got %h want a5", in_filt);
      end
      rst = 1'b1;
      #2;
      n_tests++;
      if ({in_filt, rise, fall, flags, irq} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_async got in_filt=%h rise=%h fall=%h flags=%h irq=%b want all 0",
                  in_filt, rise, fall, flags, irq);
      end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      do_reset();
      filt_len = 4'd3;
      in_raw[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_tests++;
         if (in_filt[0] !== (k >= 4 + SL) || rise[0] !== (k == 5 + SL)) begin
            n_fail++;
            $display("FAIL latency cycle %0d got in_filt0=%b rise0=%b want %b %b",
                     k, in_filt[0], rise[0], (k >= 4 + SL), (k == 5 + SL));
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      filt_len = 4'd3;
      rise_en[2] = 1'b1;
      in_raw[2] = 1'b1;
      tick();
      tick();
      in_raw[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (in_filt[2] !== 1'b0 || rise[2] !== 1'b0 || flags[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch cycle %0d got in_filt2=%b rise2=%b flags2=%b want 0 0 0",
                     k, in_filt[2], rise[2], flags[2]);
         end
      end
   endtask

   task automatic test_bypass();
      logic [4:0] pat;
      logic       prev;
      logic       v;
      do_reset();
      pat  = 5'b01101;
      prev = 1'b0;
      for (int mode = 0; mode < 3; mode++) begin
         bypass[5] = (mode != 0);
         filt_len  = (mode == 2) ? 4'd15 : 4'd0;
         for (int b = 0; b < 5; b++) begin
            v = pat[b];
            in_raw[5] = v;
            repeat (SL) tick();
            n_tests++;
            if (in_filt[5] !== prev) begin
               n_fail++;
               $display("FAIL bypass_early mode %0d step %0d got %b want %b", mode, b, in_filt[5], prev);
            end
            tick();
            n_tests++;
            if (in_filt[5] !== v) begin
               n_fail++;
               $display("FAIL bypass_follow mode %0d step %0d got %b want %b", mode, b, in_filt[5], v);
            end
            prev = v;
         end
      end
   endtask

   task automatic test_flags();
      do_reset();
      filt_len = 4'd0;
      rise_en[1] = 1'b1;
      irq_mask[1] = 1'b1;
      in_raw[1] = 1'b1;
      repeat (SL + 2) tick();
      n_tests++;
      if (rise[1] !== 1'b1 || flags[1] !== 1'b0) begin
         n_fail++; $display("FAIL flag_pre got rise1=%b flags1=%b want 1 0", rise[1], flags[1]);
      end
      tick();
      n_tests++;
      if (flags[1] !== 1'b1 || irq !== 1'b1) begin
         n_fail++; $display("FAIL flag_set got flags1=%b irq=%b want 1 1", flags[1], irq);
      end
      in_raw[1] = 1'b0;
      repeat (SL + 2) tick();
      n_tests++;
      if (fall[1] !== 1'b1 || rise[1] !== 1'b0) begin
         n_fail++; $display("FAIL fall_pulse got fall1=%b rise1=%b want 1 0", fall[1], rise[1]);
      end
      in_raw[1] = 1'b1;
      repeat (SL + 2) tick();
      n_tests++;
      if (rise[1] !== 1'b1) begin
         n_fail++; $display("FAIL rise_again got %b want 1", rise[1]);
      end
      flag_clr[1] = 1'b1;
      tick();
      flag_clr[1] = 1'b0;
      n_tests++;
      if (flags[1] !== 1'b1 || irq !== 1'b1) begin
         n_fail++; $display("FAIL set_wins got flags1=%b irq=%b want 1 1", flags[1], irq);
      end
      flag_clr[1] = 1'b1;
      tick();
      flag_clr[1] = 1'b0;
      n_tests++;
      if (flags[1] !== 1'b0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL flag_clear got flags1=%b irq=%b want 0 0", flags[1], irq);
      end
      rise_en[6] = 1'b1;
      in_raw[6] = 1'b1;
      repeat (SL + 3) tick();
      n_tests++;
      if (flags !== 8'h40 || irq !== 1'b0) begin
         n_fail++; $display("FAIL irq_masked got flags=%h irq=%b want 40 0", flags, irq);
      end
   endtask

   task automatic test_len_change_reset();
      do_reset();
      rise_en = 8'hFF;
      filt_len = 4'd7;
      in_raw[3] = 1'b1;
      repeat (SL + 5) tick();
      n_tests++;
      if (in_filt[3] !== 1'b0) begin
         n_fail++; $display("FAIL len_midcount got %b want 0", in_filt[3]);
      end
      filt_len = 4'd2;
      tick();
      n_tests++;
      if (in_filt[3] !== 1'b1) begin
         n_fail++; $display("FAIL len_lowered got %b want 1", in_filt[3]);
      end
      tick();
      tick();
      in_raw[3] = 1'b0;
      filt_len = 4'd7;
      repeat (SL + 3) tick();
      n_tests++;
      if (flags[3] !== 1'b1 || in_filt[3] !== 1'b1) begin
         n_fail++; $display("FAIL pre_rst got flags3=%b in_filt3=%b want 1 1", flags[3], in_filt[3]);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({in_filt, rise, fall, flags, irq} !== 33'd0) begin
         n_fail++;
         $display("FAIL midcount_rst got in_filt=%h rise=%h fall=%h flags=%h irq=%b want all 0",
                  in_filt, rise, fall, flags, irq);
      end
      tick();
      rst = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (in_filt !== 8'h00 || flags !== 8'h00) begin
         n_fail++; $display("FAIL post_rst got in_filt=%h flags=%h want 00 00", in_filt, flags);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_raw = '0; bypass = '0; rise_en = '0; fall_en = '0;
      irq_mask = '0; flag_clr = '0; filt_len = '0;
      test_reset();
      test_latency();
      test_glitch();
      test_bypass();
      test_flags();
      test_len_change_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
